// File: rtl/dac_frame_tx.sv
// Dual-edge DAC frame transmitter: sends a zero-data sync preamble, then streams,
// ramps, holds a constant or sends zeros, with a frame marker aligned to the data.
module dac_frame_tx #(
   parameter int NCH         = 2,
   parameter int DW          = 16,
   parameter int FRAME_LEN   = 2,
   parameter int SYNC_FRAMES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic [DW-1:0]         const_val,
   input  logic [2*NCH*DW-1:0]   in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [NCH*DW-1:0]     out_d1,
   output logic [NCH*DW-1:0]     out_d2,
   output logic                  out_frame,
   output logic                  active,
   output logic [15:0]           underflow_cnt
);

   localparam int FW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic [FW-1:0] FLAST     = FW'(FRAME_LEN - 1);
   localparam logic [FW-1:0] FHALF     = FW'(FRAME_LEN / 2);
   localparam logic [7:0]    SYNC_LAST = 8'(SYNC_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_e;
   typedef enum logic [1:0] {M_STREAM, M_ZERO, M_RAMP, M_CONST} mode_e;

   state_e             state_q;
   mode_e              mode_q;
   mode_e              modeEff;
   logic [FW-1:0]      fcnt_q;
   logic [7:0]         syncCnt_q;
   logic [DW-1:0]      ramp_q, ramp_d;
   logic [15:0]        uf_q, uf_d;
   logic [NCH*DW-1:0]  d1_q, d1_d, d2_q, d2_d;
   logic               frame_q;
   logic               active_q;

   // The mode input is only looked at on the first cycle of a frame, so the new
   // mode already governs that cycle's samples and in_ready.
   always_comb begin
      modeEff = mode_q;
      if ((state_q == SYNC || state_q == RUN) && fcnt_q == '0) begin
         modeEff = mode_e'(mode);
      end
      in_ready = (state_q == RUN) && (modeEff == M_STREAM);
   end

   // Next sample values; everything outside RUN is silent and the ramp restarts.
   always_comb begin
      d1_d   = '0;
      d2_d   = '0;
      ramp_d = '0;
      uf_d   = uf_q;
      if (state_q == RUN) begin
         ramp_d = ramp_q;
         case (modeEff)
            M_STREAM: begin
               if (in_valid) begin
                  for (int c = 0; c < NCH; c++) begin
                     d1_d[c*DW +: DW] = in_data[2*c*DW +: DW];
                     d2_d[c*DW +: DW] = in_data[(2*c+1)*DW +: DW];
                  end
               end else if (uf_q != 16'hFFFF) begin
                  uf_d = uf_q + 16'd1;
               end
            end
            M_RAMP: begin
               for (int c = 0; c < NCH; c++) begin
                  d1_d[c*DW +: DW] = ramp_q;
                  d2_d[c*DW +: DW] = ramp_q + DW'(1);
               end
               ramp_d = ramp_q + DW'(2);
            end
            M_CONST: begin
               for (int c = 0; c < NCH; c++) begin
                  d1_d[c*DW +: DW] = const_val;
                  d2_d[c*DW +: DW] = const_val;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Sequencer and registered outputs. Leaving SYNC or DRAIN always happens on the
   // last cycle of a frame, so the frame counter is already back at 0 in IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         mode_q    <= M_STREAM;
         fcnt_q    <= '0;
         syncCnt_q <= '0;
         ramp_q    <= '0;
         uf_q      <= '0;
         d1_q      <= '0;
         d2_q      <= '0;
         frame_q   <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         mode_q   <= modeEff;
         ramp_q   <= ramp_d;
         uf_q     <= uf_d;
         d1_q     <= d1_d;
         d2_q     <= d2_d;
         frame_q  <= (state_q != IDLE) && (fcnt_q < FHALF);
         active_q <= (state_q == RUN);

         if (state_q == IDLE) begin
            fcnt_q <= '0;
         end else begin
            fcnt_q <= (fcnt_q == FLAST) ? '0 : fcnt_q + FW'(1);
         end

         case (state_q)
            IDLE: begin
               syncCnt_q <= '0;
               if (enable) begin
                  state_q <= SYNC;
               end
            end
            SYNC: begin
               if (fcnt_q == FLAST) begin
                  if (!enable) begin
                     state_q   <= IDLE;
                     syncCnt_q <= '0;
                  end else if (syncCnt_q == SYNC_LAST) begin
                     state_q   <= RUN;
                     syncCnt_q <= '0;
                  end else begin
                     syncCnt_q <= syncCnt_q + 8'd1;
                  end
               end
            end
            RUN: begin
               if (!enable) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (fcnt_q == FLAST) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_d1        = d1_q;
   assign out_d2        = d2_q;
   assign out_frame     = frame_q;
   assign active        = active_q;
   assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_dac_frame_tx.sv
// Bench for dac_frame_tx: two instances (default framing and an 8-cycle frame)
// compared every cycle against a cycle-count based reference model.
module tb_dac_frame_tx;

   localparam int NCH  = 2;
   localparam int DW   = 16;
   localparam int FL_A = 2;
   localparam int SF_A = 4;
   localparam int FL_B = 8;
   localparam int SF_B = 3;

   localparam int S_IDLE  = 0;
   localparam int S_SYNC  = 1;
   localparam int S_RUN   = 2;
   localparam int S_DRAIN = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enA = 1'b0, enB = 1'b0;
   logic [1:0]    modeA = 2'd0, modeB = 2'd0;
   logic [DW-1:0] constVal = '0;
   logic [63:0]   inData = '0;
   logic          inValid = 1'b0;

   logic          readyA, readyB, frameA, frameB, activeA, activeB;
   logic [31:0]   d1A, d2A, d1B, d2B;
   logic [15:0]   ufA, ufB;

   // t counts cycles since leaving IDLE, so frame position is simply t % frameLen;
   // rampN counts ramp samples emitted since RUN entry.
   typedef struct {
      int          st;
      int          t;
      int          md;
      int          rampN;
      int          uf;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        frame;
      logic        act;
   } mdl_t;

   mdl_t mdl[2];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dac_frame_tx #(.NCH(NCH), .DW(DW), .FRAME_LEN(FL_A), .SYNC_FRAMES(SF_A)) dutA (
      .clk(clk), .reset(reset), .enable(enA), .mode(modeA), .const_val(constVal),
      .in_data(inData), .in_valid(inValid), .in_ready(readyA), .out_d1(d1A),
      .out_d2(d2A), .out_frame(frameA), .active(activeA), .underflow_cnt(ufA));

   dac_frame_tx #(.NCH(NCH), .DW(DW), .FRAME_LEN(FL_B), .SYNC_FRAMES(SF_B)) dutB (
      .clk(clk), .reset(reset), .enable(enB), .mode(modeB), .const_val(constVal),
      .in_data(inData), .in_valid(inValid), .in_ready(readyB), .out_d1(d1B),
      .out_d2(d2B), .out_frame(frameB), .active(activeB), .underflow_cnt(ufB));

   function automatic mdl_t resetModel();
      mdl_t m;
      m.st = S_IDLE; m.t = 0; m.md = 0; m.rampN = 0; m.uf = 0;
      m.d1 = '0; m.d2 = '0; m.frame = 1'b0; m.act = 1'b0;
      return m;
   endfunction

   function automatic int effMode(mdl_t m, logic [1:0] modeIn, int fl);
      if ((m.st == S_SYNC || m.st == S_RUN) && (m.t % fl) == 0) return int'(modeIn);
      return m.md;
   endfunction

   function automatic logic modelReady(mdl_t m, logic [1:0] modeIn, int fl);
      return (m.st == S_RUN) && (effMode(m, modeIn, fl) == 0);
   endfunction

   // Expected outputs after the next edge plus the advanced model state.
   function automatic mdl_t stepModel(mdl_t m, logic en, logic [1:0] modeIn, int fl, int sf);
      mdl_t        n;
      int          pos;
      int          eff;
      logic [15:0] v, w;
      n     = m;
      pos   = m.t % fl;
      eff   = effMode(m, modeIn, fl);
      n.md  = eff;
      n.frame = (m.st != S_IDLE) && (pos < fl / 2);
      n.act = (m.st == S_RUN);
      n.d1  = '0;
      n.d2  = '0;
      n.rampN = 0;
      if (m.st == S_RUN) begin
         n.rampN = m.rampN;
         if (eff == 0) begin
            if (inValid) begin
               n.d1 = {inData[47:32], inData[15:0]};
               n.d2 = {inData[63:48], inData[31:16]};
            end else begin
               n.uf = (m.uf < 65535) ? m.uf + 1 : 65535;
            end
         end else if (eff == 2) begin
            v = 16'((2 * m.rampN) % 65536);
            w = 16'((2 * m.rampN + 1) % 65536);
            n.d1 = {v, v};
            n.d2 = {w, w};
            n.rampN = m.rampN + 1;
         end else if (eff == 3) begin
            n.d1 = {constVal, constVal};
            n.d2 = {constVal, constVal};
         end
      end
      case (m.st)
         S_IDLE: begin
            n.t = 0;
            if (en) n.st = S_SYNC;
         end
         S_SYNC: begin
            n.t = m.t + 1;
            if (pos == fl - 1) begin
               if (!en) begin
                  n.st = S_IDLE;
                  n.t  = 0;
               end else if (m.t + 1 == sf * fl) begin
                  n.st = S_RUN;
               end
            end
         end
         S_RUN: begin
            n.t = m.t + 1;
            if (!en) n.st = S_DRAIN;
         end
         default: begin
            n.t = m.t + 1;
            if (pos == fl - 1) begin
               n.st = S_IDLE;
               n.t  = 0;
            end
         end
      endcase
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkReady();
      chk("A_in_ready", 32'(readyA), 32'(modelReady(mdl[0], modeA, FL_A)));
      chk("B_in_ready", 32'(readyB), 32'(modelReady(mdl[1], modeB, FL_B)));
   endtask

   task automatic checkOutput();
      chk("A_out_d1", d1A, mdl[0].d1);
      chk("A_out_d2", d2A, mdl[0].d2);
      chk("A_out_frame", 32'(frameA), 32'(mdl[0].frame));
      chk("A_active", 32'(activeA), 32'(mdl[0].act));
      chk("A_underflow", 32'(ufA), 32'(mdl[0].uf));
      chk("B_out_d1", d1B, mdl[1].d1);
      chk("B_out_d2", d2B, mdl[1].d2);
      chk("B_out_frame", 32'(frameB), 32'(mdl[1].frame));
      chk("B_active", 32'(activeB), 32'(mdl[1].act));
      chk("B_underflow", 32'(ufB), 32'(mdl[1].uf));
   endtask

   // One clock: check combinational ready, predict, clock, check registered outputs.
   task automatic applyStimulus();
      mdl_t nA, nB;
      checkReady();
      nA = stepModel(mdl[0], enA, modeA, FL_A, SF_A);
      nB = stepModel(mdl[1], enB, modeB, FL_B, SF_B);
      @(posedge clk);
      #1;
      mdl[0] = nA;
      mdl[1] = nB;
      checkOutput();
   endtask

   task automatic randomData();
      inData  = {$urandom, $urandom};
      inValid = ($urandom_range(0, 3) != 0);
   endtask

   task automatic waitPos(input int i, input int st, input int pos);
      int fl;
      int k;
      fl = (i == 0) ? FL_A : FL_B;
      k  = 0;
      while (!(mdl[i].st == st && (mdl[i].t % fl) == pos) && k < 300) begin
         randomData();
         applyStimulus();
         k++;
      end
      checks++;
      assert (mdl[i].st == st && (mdl[i].t % fl) == pos) else begin
         errors++;
         $error("[TB] FAIL wait_dut%0d observed=timeout expected=state%0d_pos%0d", i, st, pos);
      end
   endtask

   // Reset lands mid-cycle; outputs and in_ready must clear without a clock edge.
   task automatic pulseReset();
      #2 reset = 1'b1;
      #1;
      mdl[0] = resetModel();
      mdl[1] = resetModel();
      checkOutput();
      checkReady();
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput();
   endtask

   initial begin
      mdl[0] = resetModel();
      mdl[1] = resetModel();
      $display("[TB] start");
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput();
      checkReady();

      // Ramp on A, random stream on B through both preambles
      modeA = 2'd2; modeB = 2'd0; enA = 1'b1; enB = 1'b1; constVal = 16'h0ABC;
      repeat (40) begin
         randomData();
         applyStimulus();
      end

      inData  = 64'h4444_3333_2222_1111;
      inValid = 1'b1;
      applyStimulus();
      chk("B_stream_d1_fixed", d1B, 32'h3333_1111);
      chk("B_stream_d2_fixed", d2B, 32'h4444_2222);

      inValid = 1'b0;
      repeat (3) applyStimulus();

      // Mode change mid-frame on B takes effect at the next frame start
      waitPos(1, S_RUN, 3);
      modeB = 2'd3;
      repeat (12) begin
         randomData();
         applyStimulus();
      end
      chk("B_const_d1", d1B, 32'h0ABC_0ABC);
      modeB = 2'd0;

      // A walks through zero and constant modes, then back to ramp
      modeA = 2'd1;
      repeat (5) applyStimulus();
      modeA = 2'd3;
      repeat (5) applyStimulus();
      modeA = 2'd2;

      // Drop enable on B at fcnt=2; re-raising it during DRAIN is ignored
      waitPos(1, S_RUN, 2);
      enB = 1'b0;
      applyStimulus();
      repeat (2) applyStimulus();
      enB = 1'b1;
      repeat (14) begin
         randomData();
         applyStimulus();
      end

      // Long underflow run on B saturates the counter; ramp on A wraps
      waitPos(1, S_RUN, 0);
      inValid = 1'b0;
      repeat (65540) begin
         inData = {$urandom, $urandom};
         applyStimulus();
      end
      chk("B_underflow_saturated", 32'(ufB), 32'h0000_FFFF);

      inValid = 1'b1;
      repeat (5) applyStimulus();
      pulseReset();

      // Re-enable; A drops enable mid-SYNC and returns to IDLE at the frame end
      repeat (3) applyStimulus();
      enA = 1'b0;
      repeat (6) applyStimulus();
      enA = 1'b1;
      repeat (45) begin
         randomData();
         applyStimulus();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_frame_tx.md
DAC_FRAME_TX -- requirements
Module: dac_frame_tx

Interface
REQ-001 Parameter NCH, default 2: number of DAC data channels (1..8).
REQ-002 Parameter DW, default 16: sample width per channel in bits (8..16).
REQ-003 Parameter FRAME_LEN, default 2: frame period in clk cycles; even, 2..64.
REQ-004 Parameter SYNC_FRAMES, default 4: whole frames of zero data sent before data is accepted (1..255).
REQ-005 clk  in  1  sample clock; all logic is on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  level; 1 requests streaming, 0 requests stop.
REQ-008 mode  in  2  0 = stream, 1 = zero, 2 = ramp, 3 = constant.
REQ-009 const_val  in  DW  sample value used in constant mode.
REQ-010 in_data  in  2*NCH*DW  channel c: first sample at [2c*DW +: DW], second sample at [(2c+1)*DW +: DW].
REQ-011 in_valid  in  1  in_data is valid.
REQ-012 in_ready  out  1  block accepts in_data this cycle.
REQ-013 out_d1  out  NCH*DW  first-edge sample per channel (channel c at [c*DW +: DW]), registered.
REQ-014 out_d2  out  NCH*DW  second-edge sample per channel, same layout, registered.
REQ-015 out_frame  out  1  frame marker, registered.
REQ-016 active  out  1  high while the state is RUN.
REQ-017 underflow_cnt  out  16  saturating count of stream-mode underflows.

Function
REQ-018 The frame counter fcnt runs 0..FRAME_LEN-1 and wraps; it advances every cycle outside IDLE and is held at 0 in IDLE.
REQ-019 out_frame is 1 when fcnt < FRAME_LEN/2 and 0 otherwise, registered with the same latency as the data; out_frame is 0 in IDLE.
REQ-020 The state machine has four states: IDLE, SYNC, RUN, DRAIN.
REQ-021 IDLE to SYNC occurs when enable=1; fcnt starts at 0 in the first SYNC cycle.
REQ-022 SYNC to RUN occurs at the end of frame SYNC_FRAMES (fcnt = FRAME_LEN-1 and frame counter = SYNC_FRAMES-1).
REQ-023 RUN to DRAIN occurs when enable=0; DRAIN to IDLE occurs on the cycle with fcnt = FRAME_LEN-1.
REQ-024 enable=0 during SYNC returns the block to IDLE at the next frame end.
REQ-025 enable=1 during DRAIN is ignored until IDLE is reached.
REQ-026 The effective mode is sampled from the mode input only when fcnt = 0 in SYNC or RUN; a mode change mid-frame takes effect at the next frame start.
REQ-027 in_ready = 1 only in RUN with effective mode = stream; it is combinational from state and effective mode only, never from in_valid.
REQ-028 Transfer occurs when in_valid and in_ready are both 1; out_d1 and out_d2 show the transferred samples 1 cycle later.
REQ-029 Stream mode, RUN, in_valid=0: outputs are all zero for that cycle and underflow_cnt increments, saturating at 0xFFFF.
REQ-030 Zero mode: all outputs are 0.
REQ-031 Constant mode: every d1 and d2 slot is const_val.
REQ-032 Ramp mode: ramp register r starts at 0 on RUN entry; each cycle out_d1 = r and out_d2 = r+1 in every channel; r advances by 2 modulo 2^DW.
REQ-033 In IDLE, SYNC and DRAIN, out_d1 and out_d2 are 0 regardless of mode or input.
REQ-034 active equals (state == RUN), registered.
REQ-035 underflow_cnt clears only on reset.

Reset
REQ-036 Reset forces state IDLE, fcnt 0, frame counter 0, r 0, effective mode 0.
REQ-037 Reset drives out_d1, out_d2, out_frame, active and underflow_cnt to 0.
REQ-038 Reset asserted mid-stream aborts immediately with no drain; in_ready drops in the same cycle.

Verification
REQ-039 Defaults, enable=1, mode=2 -> out_frame pattern 1,0,1,0; active rises after 8 cycles; then d1/d2 = 0/1, 2/3, 4/5 on both channels; wraps 0xFFFE/0xFFFF to 0/1.
REQ-040 Stream mode, in_data=0x4444_3333_2222_1111 with in_valid held -> out_d1 ch0=0x1111, ch1=0x3333; out_d2 ch0=0x2222, ch1=0x4444, one cycle after transfer.
REQ-041 Stream mode, in_valid low for 3 RUN cycles -> 3 zero output cycles; underflow_cnt = 3; counter preset near 0xFFFF saturates at 0xFFFF.
REQ-042 FRAME_LEN=8, enable dropped at fcnt=2 -> state DRAIN until fcnt=7, then IDLE; in_ready = 0 from the cycle after the drop.
REQ-043 Mode written 3 (const_val=0x0ABC) at fcnt=3, FRAME_LEN=8 -> outputs change to 0x0ABC only at the next fcnt=0.
REQ-044 Reset pulse in RUN -> all outputs 0 and state IDLE asynchronously; re-enable repeats the full SYNC_FRAMES preamble.
